// File: rtl/ast_arb_pkg.sv
// Shared types and the round-robin pick helper for the AST packet arbiter.
// rr_pick is sized for up to RR_MAX_N inputs; callers zero-extend their vectors.
package ast_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  localparam int RR_MAX_W = 6;
  localparam int RR_MAX_N = 1 << RR_MAX_W;

  typedef struct packed {
    logic                found;
    logic [RR_MAX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping at n. idx falls back to ptr.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input logic [RR_MAX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t          res;
    logic [RR_MAX_W:0] pos;
    res     = '0;
    res.idx = ptr;
    for (int k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !res.found) begin
        pos = {1'b0, ptr} + (RR_MAX_W+1)'(k);
        if (pos >= (RR_MAX_W+1)'(n)) pos = pos - (RR_MAX_W+1)'(n);
        if (valid[pos[RR_MAX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[RR_MAX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ast_skid_buffer.sv
// Two-entry Avalon-ST output buffer; full is registered so upstream ready
// never sees downstream ready combinationally.
module ast_skid_buffer
  import ast_arb_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int AST_SYMBOLS = 1,
  parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS)
) (
  input  logic                                  clk_i,
  input  logic                                  srst_n_i,
  input  logic                                  push_i,
  input  logic [AST_SYMBOLS-1:0][BYTE_W-1:0]    data_i,
  input  logic [AST_EMPTY_W-1:0]                empty_i,
  input  logic                                  sop_i,
  input  logic                                  eop_i,
  output logic                                  full_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [AST_SYMBOLS-1:0][BYTE_W-1:0]    data_o,
  output logic [AST_EMPTY_W-1:0]                empty_o,
  output logic                                  sop_o,
  output logic                                  eop_o
);

  localparam int DW = AST_SYMBOLS * BYTE_W;
  localparam int EW = DW + AST_EMPTY_W + 2;

  logic [1:0][EW-1:0] mem_q;
  logic               wr_q, rd_q;
  logic [1:0]         cnt_q, cnt_d;
  logic               pop;

  assign full_o  = (cnt_q == 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign pop     = valid_o && ready_i;
  assign {data_o, empty_o, sop_o, eop_o} = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= {data_i, empty_i, sop_i, eop_i};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ast_rr_packet_arbiter.sv
// Packet-atomic round-robin merge of IN_DIRS_CNT Avalon-ST sinks onto one source.
// A packet that starts on an input holds the grant until its eop is accepted.
module ast_rr_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int IN_DIRS_CNT = 8,
  parameter int AST_SYMBOLS = 1,
  parameter int AST_EMPTY_W = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS)
) (
  input  logic                                               clk_i,
  input  logic                                               srst_n_i,
  input  logic [IN_DIRS_CNT-1:0][AST_SYMBOLS-1:0][BYTE_W-1:0] ast_sink_data_i,
  input  logic [IN_DIRS_CNT-1:0]                             ast_sink_valid_i,
  output logic [IN_DIRS_CNT-1:0]                             ast_sink_ready_o,
  input  logic [IN_DIRS_CNT-1:0][AST_EMPTY_W-1:0]            ast_sink_empty_i,
  input  logic [IN_DIRS_CNT-1:0]                             ast_sink_startofpacket_i,
  input  logic [IN_DIRS_CNT-1:0]                             ast_sink_endofpacket_i,
  output logic [AST_SYMBOLS-1:0][BYTE_W-1:0]                 ast_source_data_o,
  output logic                                               ast_source_valid_o,
  input  logic                                               ast_source_ready_i,
  output logic [AST_EMPTY_W-1:0]                             ast_source_empty_o,
  output logic                                               ast_source_startofpacket_o,
  output logic                                               ast_source_endofpacket_o,
  output logic [$clog2(IN_DIRS_CNT)-1:0]                     grant_o,
  output logic                                               proto_err_o
);

  localparam int GW = $clog2(IN_DIRS_CNT);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
  logic [GW-1:0] cand_idx, sel, sel_nxt;
  logic          cand_found;
  logic          err_q, err_d;
  logic          en_q;
  logic          buf_full, rdy_any, push, sel_sop, sel_eop;
  rr_pick_t      pick;

  always_comb begin
    pick       = rr_pick(RR_MAX_N'(ast_sink_valid_i), RR_MAX_W'(ptr_q), IN_DIRS_CNT);
    cand_found = pick.found;
    cand_idx   = GW'(pick.idx);
  end

  // en_q keeps every ready low for the first cycle out of reset.
  assign sel     = (state_q == LOCKED) ? gnt_q : cand_idx;
  assign sel_nxt = (sel == GW'(IN_DIRS_CNT - 1)) ? '0 : sel + 1'b1;
  assign rdy_any = en_q && !buf_full && ((state_q == LOCKED) || cand_found);
  assign push    = rdy_any && ast_sink_valid_i[sel];
  assign sel_sop = ast_sink_startofpacket_i[sel];
  assign sel_eop = ast_sink_endofpacket_i[sel];

  always_comb begin
    ast_sink_ready_o      = '0;
    ast_sink_ready_o[sel] = rdy_any;
  end

  assign grant_o     = en_q ? sel : '0;
  assign proto_err_o = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (push) begin
        if (!sel_sop) err_d = 1'b1;
        if (sel_eop) ptr_d = sel_nxt;
        else begin
          gnt_d   = sel;
          state_d = LOCKED;
        end
      end
      LOCKED: if (push) begin
        if (sel_sop) err_d = 1'b1;
        if (sel_eop) begin
          ptr_d   = sel_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  ast_skid_buffer #(
    .BYTE_W      (BYTE_W),
    .AST_SYMBOLS (AST_SYMBOLS),
    .AST_EMPTY_W (AST_EMPTY_W)
  ) u_buf (
    .clk_i    (clk_i),
    .srst_n_i (srst_n_i),
    .push_i   (push),
    .data_i   (ast_sink_data_i[sel]),
    .empty_i  (ast_sink_empty_i[sel]),
    .sop_i    (sel_sop),
    .eop_i    (sel_eop),
    .full_o   (buf_full),
    .valid_o  (ast_source_valid_o),
    .ready_i  (ast_source_ready_i),
    .data_o   (ast_source_data_o),
    .empty_o  (ast_source_empty_o),
    .sop_o    (ast_source_startofpacket_o),
    .eop_o    (ast_source_endofpacket_o)
  );

endmodule

// File: tb/tb_ast_rr_packet_arbiter.sv
// Directed scoreboard bench for ast_rr_packet_arbiter: per-input beat queues feed
// the sinks, expected source beats are queued by hand, a monitor pops and compares.
module tb_ast_rr_packet_arbiter;

  localparam int N = 8;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       emp;
    logic [7:0] data;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    srst_n;
  logic [N-1:0][0:0][7:0]  ast_sink_data_i;
  logic [N-1:0]            ast_sink_valid_i;
  logic [N-1:0]            ast_sink_ready_o;
  logic [N-1:0][0:0]       ast_sink_empty_i;
  logic [N-1:0]            ast_sink_sop_i, ast_sink_eop_i;
  logic [0:0][7:0]         src_data;
  logic                    src_valid, src_ready;
  logic [0:0]              src_empty;
  logic                    src_sop, src_eop;
  logic [2:0]              grant;
  logic                    proto_err;

  ast_rr_packet_arbiter #(.BYTE_W(8), .IN_DIRS_CNT(N), .AST_SYMBOLS(1), .AST_EMPTY_W(1)) dut (
    .clk_i                      (clk),
    .srst_n_i                   (srst_n),
    .ast_sink_data_i            (ast_sink_data_i),
    .ast_sink_valid_i           (ast_sink_valid_i),
    .ast_sink_ready_o           (ast_sink_ready_o),
    .ast_sink_empty_i           (ast_sink_empty_i),
    .ast_sink_startofpacket_i   (ast_sink_sop_i),
    .ast_sink_endofpacket_i     (ast_sink_eop_i),
    .ast_source_data_o          (src_data),
    .ast_source_valid_o         (src_valid),
    .ast_source_ready_i         (src_ready),
    .ast_source_empty_o         (src_empty),
    .ast_source_startofpacket_o (src_sop),
    .ast_source_endofpacket_o   (src_eop),
    .grant_o                    (grant),
    .proto_err_o                (proto_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  beat_t srcq [N][$];
  beat_t sb [$];
  int    out_cyc [$];
  bit    acc_arm = 0;
  int    acc_cyc = 0;
  bit    atom_arm = 0;
  int    atom_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic load(input int i, input int n, input bit single);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.sop  = single || (k == 0);
      b.eop  = single || (k == n - 1);
      b.emp  = b.eop;
      b.data = {i[3:0], k[3:0]};
      srcq[i].push_back(b);
    end
  endtask

  task automatic push_raw(input int i, input logic sop, input logic eop, input logic emp, input logic [7:0] d);
    beat_t b;
    b.sop = sop; b.eop = eop; b.emp = emp; b.data = d;
    srcq[i].push_back(b);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic sop, input logic eop, input logic emp);
    beat_t b;
    b.sop = sop; b.eop = eop; b.emp = emp; b.data = d;
    sb.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #2;
    chk(name, sb.size(), 0);
  endtask

  task automatic wait_q(input string name, input int i, input int sz, input int budget);
    int n = 0;
    while (srcq[i].size() != sz && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, srcq[i].size(), sz);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 srst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 srst_n = 1'b1;
    out_cyc.delete();
  endtask

  // Sink driver: handshakes are judged at negedge, beats advance just after posedge.
  initial begin
    logic [N-1:0] fire;
    ast_sink_valid_i = '0;
    ast_sink_data_i  = '0;
    ast_sink_empty_i = '0;
    ast_sink_sop_i   = '0;
    ast_sink_eop_i   = '0;
    forever begin
      @(negedge clk);
      fire = ast_sink_valid_i & ast_sink_ready_o;
      if (acc_arm && fire != '0) begin
        acc_cyc = cyc;
        acc_arm = 0;
      end
      if (atom_arm && ast_sink_ready_o[0]) atom_viol++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
        if (srcq[i].size() != 0) begin
          ast_sink_valid_i[i]   = 1'b1;
          ast_sink_data_i[i][0] = srcq[i][0].data;
          ast_sink_empty_i[i]   = srcq[i][0].emp;
          ast_sink_sop_i[i]     = srcq[i][0].sop;
          ast_sink_eop_i[i]     = srcq[i][0].eop;
        end else begin
          ast_sink_valid_i[i]   = 1'b0;
          ast_sink_data_i[i][0] = '0;
          ast_sink_empty_i[i]   = '0;
          ast_sink_sop_i[i]     = 1'b0;
          ast_sink_eop_i[i]     = 1'b0;
        end
      end
    end
  end

  // Monitor: every source transfer pops one expected beat.
  initial begin
    beat_t got, want;
    forever begin
      @(negedge clk);
      if (srst_n && src_valid && src_ready) begin
        got = {src_sop, src_eop, src_empty, src_data[0]};
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got %0h want none", got);
        end else begin
          want = sb.pop_front();
          chk("sb_beat", 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    srst_n    = 1'b0;
    src_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", src_valid, 0);
    chk("rst_ready", ast_sink_ready_o, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_data", {src_sop, src_eop, src_empty, src_data[0]}, 0);
    @(posedge clk);
    #2 srst_n = 1'b1;

    // single 3-beat packet from input 2
    out_cyc.delete();
    acc_arm = 1;
    load(2, 3, 0);
    expect_beat(8'h20, 1, 0, 0);
    expect_beat(8'h21, 0, 0, 0);
    expect_beat(8'h22, 0, 1, 1);
    wait_drain("s1_drain", 50);
    chk("s1_count", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      chk("s1_latency", out_cyc[0], acc_cyc + 1);
      chk("s1_consec", out_cyc[2] - out_cyc[0], 2);
    end

    // fairness across inputs 0,1,3 with single-beat packets
    do_reset();
    load(0, 3, 1);
    load(1, 3, 1);
    load(3, 3, 1);
    expect_beat(8'h00, 1, 1, 1); expect_beat(8'h10, 1, 1, 1); expect_beat(8'h30, 1, 1, 1);
    expect_beat(8'h01, 1, 1, 1); expect_beat(8'h11, 1, 1, 1); expect_beat(8'h31, 1, 1, 1);
    expect_beat(8'h02, 1, 1, 1); expect_beat(8'h12, 1, 1, 1); expect_beat(8'h32, 1, 1, 1);
    wait_drain("s2_drain", 60);
    chk("s2_count", out_cyc.size(), 9);
    if (out_cyc.size() == 9) chk("s2_no_gaps", out_cyc[8] - out_cyc[0], 8);

    // atomicity: input 0 shows up mid-packet of input 1
    do_reset();
    load(1, 4, 0);
    wait_q("s3_first_accept", 1, 3, 20);
    load(0, 2, 0);
    atom_arm = 1;
    expect_beat(8'h10, 1, 0, 0);
    expect_beat(8'h11, 0, 0, 0);
    expect_beat(8'h12, 0, 0, 0);
    expect_beat(8'h13, 0, 1, 1);
    expect_beat(8'h00, 1, 0, 0);
    expect_beat(8'h01, 0, 1, 1);
    wait_q("s3_in1_done", 1, 0, 20);
    atom_arm = 0;
    wait_drain("s3_drain", 50);
    chk("s3_ready0_locked_out", atom_viol, 0);

    // backpressure mid-packet
    do_reset();
    src_ready = 1'b0;
    load(5, 6, 0);
    expect_beat(8'h50, 1, 0, 0);
    expect_beat(8'h51, 0, 0, 0);
    expect_beat(8'h52, 0, 0, 0);
    expect_beat(8'h53, 0, 0, 0);
    expect_beat(8'h54, 0, 0, 0);
    expect_beat(8'h55, 0, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s4_stall_valid", src_valid, 1);
    chk("s4_stall_data_a", src_data[0], 8'h50);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s4_accepted", 6 - srcq[5].size(), 2);
    chk("s4_ready_low", ast_sink_ready_o, 0);
    chk("s4_stall_data_b", src_data[0], 8'h50);
    @(posedge clk);
    #2 src_ready = 1'b1;
    wait_drain("s4_drain", 60);
    chk("s4_src_empty", srcq[5].size(), 0);
    chk("s4_no_err", proto_err, 0);

    // framing error: sop=0 while idle
    do_reset();
    @(negedge clk);
    chk("s5_err_clear", proto_err, 0);
    push_raw(4, 1'b0, 1'b1, 1'b0, 8'h40);
    expect_beat(8'h40, 0, 1, 0);
    wait_drain("s5_drain", 30);
    chk("s5_err_set", proto_err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s5_err_sticky", proto_err, 1);

    // reset during beat 2 of 5; pointer was left at 5 before this
    load(6, 5, 0);
    wait_q("s6_first_accept", 6, 4, 20);
    srst_n = 1'b0;
    @(posedge clk);
    #2 srst_n = 1'b1;
    srcq[6].delete();
    @(negedge clk);
    chk("s6_valid_drop", src_valid, 0);
    chk("s6_ready_low", ast_sink_ready_o, 0);
    chk("s6_grant_zero", grant, 0);
    chk("s6_err_clear", proto_err, 0);
    load(3, 1, 1);
    load(6, 1, 1);
    expect_beat(8'h30, 1, 1, 1);
    expect_beat(8'h60, 1, 1, 1);
    @(negedge clk);
    chk("s6_grant_restart", grant, 3);
    wait_drain("s6_drain", 30);
    chk("s6_no_err", proto_err, 0);

    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
